// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter/rotator with valid/ready handshake.
// Stage k conditionally moves the operand by 2^k according to the amount bit
// it sees. The remaining amount bits, the opcode and the running carry
// candidate travel down the pipe with the data. The whole pipe stalls as one
// unit when the output is held, and bubbles are kept in place.
module shifter_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam logic [2:0] OP_ROTL = 3'b000;
  localparam logic [2:0] OP_ROTR = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;

  logic             q_v [SHW];
  logic [WIDTH-1:0] q_d [SHW];
  logic [2:0]       q_o [SHW];
  logic [SHW-1:0]   q_a [SHW];
  logic             q_c [SHW];

  logic advance;

  // The pipe moves as a whole whenever the output slot is empty or drained.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int S = 1 << k;

    logic             sv;
    logic [WIDTH-1:0] sd;
    logic [2:0]       so;
    logic [SHW-1:0]   sa;
    logic             sc;
    logic [WIDTH-1:0] nd;
    logic             nc;

    if (k == 0) begin : g_head
      // Illegal opcodes enter as a zero operand; they match no shift case
      // below, so they exit with out=0 and carry=0.
      assign sv = in_valid;
      assign sd = (op > OP_SHR) ? '0 : in;
      assign so = op;
      assign sa = amt;
      assign sc = 1'b0;
    end else begin : g_link
      assign sv = q_v[k-1];
      assign sd = q_d[k-1];
      assign so = q_o[k-1];
      assign sa = q_a[k-1];
      assign sc = q_c[k-1];
    end

    // Conditional move by 2^k; the carry candidate is the last bit to leave
    // (or, for rotates, the bit that wraps into the vacated end).
    always_comb begin
      nd = sd;
      nc = sc;
      if (sa[0]) begin
        case (so)
          OP_ROTL: begin nd = (sd << S) | (sd >> (WIDTH - S)); nc = sd[WIDTH-S]; end
          OP_ROTR: begin nd = (sd >> S) | (sd << (WIDTH - S)); nc = sd[S-1];     end
          OP_SHL:  begin nd = sd << S;                         nc = sd[WIDTH-S]; end
          OP_SRA:  begin nd = $signed(sd) >>> S;               nc = sd[S-1];     end
          OP_SHR:  begin nd = sd >> S;                         nc = sd[S-1];     end
          default: ;
        endcase
      end
    end

    // Stage register: flush drops the slot, otherwise load on advance.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_v[k] <= 1'b0;
        q_d[k] <= '0;
        q_o[k] <= '0;
        q_a[k] <= '0;
        q_c[k] <= 1'b0;
      end else if (flush) begin
        q_v[k] <= 1'b0;
      end else if (advance) begin
        q_v[k] <= sv;
        q_d[k] <= nd;
        q_o[k] <= so;
        q_a[k] <= sa >> 1;
        q_c[k] <= nc;
      end
    end
  end

  assign out_valid = q_v[SHW-1];
  assign out       = q_d[SHW-1];
  assign carry     = q_c[SHW-1];
  assign zero      = out_valid && (out == '0);
  assign err       = out_valid && (q_o[SHW-1] > OP_SHR);

endmodule
